tag_ctrl: RTL and testbench
===========================

TAG_CTRL -- requirements
Module: tag_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): IDX_W, 6, set index width; TAG_W, 22, tag width; OFF_W, 4, line offset width; ADDR_W, 32, address width. IDX_W+TAG_W+OFF_W SHALL equal ADDR_W.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports are listed as name, direction, width, meaning.
REQ-003 clk, in, 1, sole clock, rising edge.
REQ-004 rstn, in, 1, asynchronous active-low reset.
REQ-005 req_valid / req_ready, in / out, 1 / 1, lookup request handshake.
REQ-006 req_addr, in, ADDR_W, lookup address: tag [31:10], index [9:4], offset [3:0].
REQ-007 resp_valid / resp_ready, out / in, 1 / 1, response handshake.
REQ-008 resp_hit, out, 1, 1 = hit, 0 = miss (refilled).
REQ-009 fill_req / fill_ack, out / in, 1 / 1, line refill handshake to the memory side.
REQ-010 fill_addr, out, ADDR_W, line address {tag, index, 4'b0}.
REQ-011 flush, in, 1, invalidate-all request (level).
REQ-012 tag_cs, tag_web, tag_oe, out, 1 each, tag SRAM controls: chip select, active-low write enable, output enable.
REQ-013 tag_a, out, IDX_W, tag SRAM address.
REQ-014 tag_di, out, TAG_W, tag SRAM write data.
REQ-015 tag_do, in, TAG_W, tag SRAM read data, valid the cycle after a read edge.

Function
REQ-016 The FSM SHALL have the states IDLE, CMP, MISS, WRT and RESP.
REQ-017 The block SHALL hold the valid bits in an internal 2^IDX_W-bit register, not in the SRAM.
REQ-018 req_ready SHALL equal (state==IDLE) & ~flush.
REQ-019 On accept, the block SHALL drive tag_cs=1, tag_web=1, tag_a=req_addr index combinationally in the same cycle, register tag and index, and go to CMP.
REQ-020 tag_oe SHALL be constant 1 out of reset.
REQ-021 In CMP, hit SHALL equal valid[idx_q] & (tag_do==tag_q). On hit the FSM SHALL go to RESP with resp_hit=1; on miss it SHALL go to MISS.
REQ-022 In MISS, fill_req SHALL be 1 and fill_addr SHALL equal {tag_q, idx_q, 0}, held stable until the cycle fill_ack=1, then the FSM SHALL go to WRT.
REQ-023 A fill_ack outside MISS SHALL be ignored.
REQ-024 In WRT, the block SHALL drive tag_cs=1, tag_web=0, tag_a=idx_q, tag_di=tag_q for exactly one cycle, set valid[idx_q]=1 at that edge, and go to RESP with resp_hit=0.
REQ-025 In RESP, resp_valid=1 and resp_hit SHALL be held stable until resp_ready=1, then the FSM SHALL return to IDLE.
REQ-026 In every state other than those above, tag_cs SHALL be 0, tag_web 1, and tag_a/tag_di 0.
REQ-027 Latency: a hit accepted at edge T SHALL give resp_valid high from T+2. A miss SHALL raise fill_req from T+2; resp_valid SHALL follow 2 cycles after the fill_ack edge.
REQ-028 When flush=1 in IDLE, all valid bits SHALL clear at the next edge, with no SRAM access. Flush SHALL take priority over a simultaneous req_valid.
REQ-029 A flush raised outside IDLE SHALL take effect only once IDLE is reached, if still asserted.
REQ-030 A tag SRAM read of a never-written index (X data) SHALL still yield a miss, because the valid bit is 0.

Reset
REQ-031 While rstn=0, the block SHALL force state=IDLE, valid all 0, and registered tag/index to 0.
REQ-032 While rstn=0, the outputs SHALL be: req_ready=1 after release; resp_valid, resp_hit, fill_req and tag_cs = 0; tag_web=1; tag_oe=1; tag_a, tag_di and fill_addr = 0.
REQ-033 Reset asserted mid-operation (any state) SHALL drop fill_req and resp_valid immediately, abandon the request without a response, and leave the SRAM contents untouched.

Verification
REQ-034 Cold miss: reset, then req addr 0x0000_0410 -> fill_req at T+2 with fill_addr 0x0000_0410; fill_ack -> WRT writes tag_a=1, tag_di=0x000001 -> resp_hit=0.
REQ-035 Hit after fill: repeat the same address -> resp_valid at T+2, resp_hit=1, fill_req never asserted.
REQ-036 Conflict: 0x0000_0410 then 0x0000_0810 (same index 1, tag 2) -> miss; a subsequent 0x0000_0410 -> miss.
REQ-037 Flush: fill index 1, assert flush simultaneously with req_valid -> req_ready=0 that cycle; the next request to 0x0000_0410 -> miss.
REQ-038 Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_valid and resp_hit stable; deassert rstn during MISS -> fill_req=0 immediately, state IDLE, no resp_valid.

Source files
------------

// File: rtl/tag_ctrl.sv
// tag_ctrl - tag lookup controller for a direct-mapped cache.
//
// Accepts one lookup at a time, reads the tag SRAM, and compares the stored
// tag with the request tag. On a miss it requests a line refill, writes the
// new tag back, and then responds. Valid bits live in a flop vector, so an
// index that was never written always misses.
//
// Parameters:
//   IDX_W  - set index width
//   TAG_W  - tag width
//   OFF_W  - line offset width
//   ADDR_W - address width (must equal IDX_W + TAG_W + OFF_W)
//
// Ports:
//   clk, rstn              - clock, asynchronous active-low reset
//   req_valid/req_ready    - lookup request handshake, req_addr = address
//   resp_valid/resp_ready  - response handshake, resp_hit = 1 hit / 0 refilled
//   fill_req/fill_ack      - refill handshake, fill_addr = line address
//   flush                  - level request to invalidate every line
//   tag_cs/web/oe/a/di/do  - tag SRAM port (web active low, do one cycle late)

module tag_ctrl #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned TAG_W  = 22,
    parameter int unsigned OFF_W  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic              fill_req,
    input  logic              fill_ack,
    output logic [ADDR_W-1:0] fill_addr,
    input  logic              flush,
    output logic              tag_cs,
    output logic              tag_web,
    output logic              tag_oe,
    output logic [IDX_W-1:0]  tag_a,
    output logic [TAG_W-1:0]  tag_di,
    input  logic [TAG_W-1:0]  tag_do
);

    typedef enum logic [2:0] {
        StIdle,
        StCmp,
        StMiss,
        StWrt,
        StResp
    } state_t;

    state_t              state_q;
    logic [TAG_W-1:0]    tag_q;
    logic [IDX_W-1:0]    idx_q;
    logic [2**IDX_W-1:0] valid_q;
    logic                hit_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             accept;
    logic             hit;

    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr[OFF_W +: IDX_W];

    // Offset bits play no part in a line lookup.
    logic unused_off;
    assign unused_off = ^req_addr[OFF_W-1:0];

    // Flush wins over a request arriving in the same cycle.
    assign req_ready = (state_q == StIdle) && !flush;
    assign accept    = req_ready && req_valid;

    // An unwritten index may return X data; the clear valid bit masks it.
    assign hit = valid_q[idx_q] && (tag_do == tag_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            tag_q   <= '0;
            idx_q   <= '0;
            valid_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        tag_q   <= req_tag;
                        idx_q   <= req_idx;
                        state_q <= StCmp;
                    end
                end
                StCmp: begin
                    hit_q   <= hit;
                    state_q <= hit ? StResp : StMiss;
                end
                StMiss: begin
                    if (fill_ack) begin
                        state_q <= StWrt;
                    end
                end
                StWrt: begin
                    valid_q[idx_q] <= 1'b1;
                    hit_q          <= 1'b0;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_hit   = (state_q == StResp) && hit_q;
    assign fill_req   = (state_q == StMiss);
    assign fill_addr  = (state_q == StMiss) ? {tag_q, idx_q, {OFF_W{1'b0}}} : '0;
    assign tag_oe     = 1'b1;

    // Read is issued in the accept cycle so the data is ready during compare.
    always_comb begin
        tag_cs  = 1'b0;
        tag_web = 1'b1;
        tag_a   = '0;
        tag_di  = '0;
        if (accept) begin
            tag_cs = 1'b1;
            tag_a  = req_idx;
        end else if (state_q == StWrt) begin
            tag_cs  = 1'b1;
            tag_web = 1'b0;
            tag_a   = idx_q;
            tag_di  = tag_q;
        end
    end

endmodule

// File: tb/tb_tag_ctrl.sv
// tb_tag_ctrl - self-checking bench for tag_ctrl with a behavioural cache
// directory model and a simple one-cycle-latency tag SRAM model.

module tb_tag_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic        fill_req;
    logic        fill_ack = 1'b0;
    logic [31:0] fill_addr;
    logic        flush = 1'b0;
    logic        tag_cs, tag_web, tag_oe;
    logic [5:0]  tag_a;
    logic [21:0] tag_di;
    logic [21:0] tag_do;

    int n_checks = 0;
    int n_fail = 0;

    // Directory model: what the cache should currently hold per index.
    bit         m_valid [64];
    logic [21:0] m_tag  [64];

    // Tag SRAM: garbage until written, read data one cycle after the edge.
    logic [21:0] junk    [64];
    logic [21:0] mem     [64];
    bit          written [64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tag_cs) begin
            if (!tag_web) begin
                mem[tag_a]     <= tag_di;
                written[tag_a] <= 1'b1;
            end else begin
                tag_do <= written[tag_a] ? mem[tag_a] : junk[tag_a];
            end
        end
    end

    tag_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .fill_req   (fill_req),
        .fill_ack   (fill_ack),
        .fill_addr  (fill_addr),
        .flush      (flush),
        .tag_cs     (tag_cs),
        .tag_web    (tag_web),
        .tag_oe     (tag_oe),
        .tag_a      (tag_a),
        .tag_di     (tag_di),
        .tag_do     (tag_do)
    );

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endfunction

    // One full lookup transaction, driven and checked cycle by cycle.
    task automatic lookup(input logic [31:0] addr, input int fill_dly, input int resp_dly,
                          input bit stray_ack);
        logic [5:0]  idx;
        logic [21:0] tg;
        bit          exp_hit;
        idx = addr[9:4];
        tg  = addr[31:10];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);

        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        n_checks++;
        if ({req_ready, tag_cs, tag_web, tag_a} !== {1'b1, 1'b1, 1'b1, idx}) begin
            n_fail++;
            $display("FAIL accept_read: got rdy/cs/web/a=%b%b%b/%h required 111/%h",
                     req_ready, tag_cs, tag_web, tag_a, idx);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        fill_ack  = stray_ack;
        n_checks++;
        if ({resp_valid, fill_req, tag_cs, req_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL cmp_quiet: got rv/fr/cs/rdy=%b required 0000",
                     {resp_valid, fill_req, tag_cs, req_ready});
        end
        @(negedge clk);
        fill_ack = 1'b0;
        if (exp_hit) begin
            n_checks++;
            if ({resp_valid, resp_hit, fill_req} !== 3'b110) begin
                n_fail++;
                $display("FAIL hit_latency addr=%h: got rv/hit/fr=%b required 110",
                         addr, {resp_valid, resp_hit, fill_req});
            end
        end else begin
            n_checks++;
            if ({fill_req, resp_valid, fill_addr} !== {2'b10, addr[31:4], 4'h0}) begin
                n_fail++;
                $display("FAIL miss_fill addr=%h: got fr/rv=%b%b fill_addr=%h required 10 %h",
                         addr, fill_req, resp_valid, fill_addr, {addr[31:4], 4'h0});
            end
            for (int i = 0; i < fill_dly; i++) begin
                @(negedge clk);
                n_checks++;
                if ({fill_req, tag_cs, fill_addr} !== {2'b10, addr[31:4], 4'h0}) begin
                    n_fail++;
                    $display("FAIL fill_hold: got fr/cs=%b%b fill_addr=%h required 10 %h",
                             fill_req, tag_cs, fill_addr, {addr[31:4], 4'h0});
                end
            end
            fill_ack = 1'b1;
            @(negedge clk);
            fill_ack = 1'b0;
            n_checks++;
            if ({tag_cs, tag_web, tag_a, tag_di, fill_req, resp_valid} !==
                {1'b1, 1'b0, idx, tg, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL wrt: got cs/web=%b%b a=%h di=%h fr/rv=%b%b required 10 %h %h 00",
                         tag_cs, tag_web, tag_a, tag_di, fill_req, resp_valid, idx, tg);
            end
            @(negedge clk);
            n_checks++;
            if ({resp_valid, resp_hit, tag_cs} !== 3'b100) begin
                n_fail++;
                $display("FAIL miss_resp: got rv/hit/cs=%b required 100",
                         {resp_valid, resp_hit, tag_cs});
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        for (int i = 0; i < resp_dly; i++) begin
            @(negedge clk);
            n_checks++;
            if ({resp_valid, resp_hit} !== {1'b1, exp_hit}) begin
                n_fail++;
                $display("FAIL resp_hold: got rv/hit=%b%b required 1%b",
                         resp_valid, resp_hit, exp_hit);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL resp_done: got rv/rdy=%b%b required 01", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({resp_valid, resp_hit, fill_req, tag_cs, tag_web, tag_oe} !== 6'b000011) begin
            n_fail++;
            $display("FAIL reset_ctl: got rv/hit/fr/cs/web/oe=%b required 000011",
                     {resp_valid, resp_hit, fill_req, tag_cs, tag_web, tag_oe});
        end
        n_checks++;
        if ({tag_a, tag_di, fill_addr} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got a=%h di=%h fill_addr=%h required 0",
                     tag_a, tag_di, fill_addr);
        end
        rstn = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_cold_miss_and_hit();
        lookup(32'h0000_0410, 2, 0, 1'b0);
        lookup(32'h0000_0410, 0, 0, 1'b0);
    endtask

    task automatic test_conflict();
        lookup(32'h0000_0810, 1, 0, 1'b0);
        lookup(32'h0000_0410, 0, 1, 1'b0);
        lookup(32'h0000_0410, 0, 0, 1'b0);
    endtask

    task automatic test_stray_ack();
        lookup(32'h0000_0410, 0, 0, 1'b1);
        lookup(32'h0000_0420, 0, 0, 1'b1);
    endtask

    task automatic test_flush();
        lookup(32'h0000_0410, 0, 0, 1'b0);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0410;
        #1;
        n_checks++;
        if ({req_ready, tag_cs} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_prio: got rdy/cs=%b%b required 00", req_ready, tag_cs);
        end
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, tag_cs} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_hold: got rdy/rv/cs=%b required 000",
                     {req_ready, resp_valid, tag_cs});
        end
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        lookup(32'h0000_0410, 0, 0, 1'b0);
    endtask

    task automatic test_flush_deferred();
        lookup(32'h0000_0410, 0, 0, 1'b0);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0410;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({resp_valid, resp_hit} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_deferred_hit: got rv/hit=%b%b required 11",
                     resp_valid, resp_hit);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid, tag_cs} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_idle_block: got rdy/rv/cs=%b required 000",
                     {req_ready, resp_valid, tag_cs});
        end
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        lookup(32'h0000_0410, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        lookup(32'h0000_0410, 0, 5, 1'b0);
        lookup(32'h0000_0c10, 0, 5, 1'b0);
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] addr;
        addr = {m_tag[6] + 22'd1, 6'd6, 4'h3};
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fill_req !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_miss: got fr=%b required 1", fill_req);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({fill_req, resp_valid, tag_cs, fill_addr} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid_miss: got fr/rv/cs=%b%b%b fill_addr=%h required 000 0",
                     fill_req, resp_valid, tag_cs, fill_addr);
        end
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        fill_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({resp_valid, fill_req, req_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL post_reset_idle: got rv/fr/rdy=%b required 001",
                         {resp_valid, fill_req, req_ready});
            end
        end
        fill_ack = 1'b0;
        lookup(32'h0000_0410, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            addr = {22'($urandom_range(1, 3)), 6'($urandom_range(0, 3)), 4'($urandom)};
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                #1;
                n_checks++;
                if (req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_flush_ready: got %b required 0", req_ready);
                end
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
            lookup(addr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            junk[i]  = 22'($urandom);
            m_tag[i] = '0;
        end
        // Make an unwritten entry look like a tag match to exercise the valid bit.
        junk[1] = 22'h000001;
        junk[6] = 22'h000000;
        @(negedge clk);
        test_reset();
        test_cold_miss_and_hit();
        test_conflict();
        test_stray_ack();
        test_flush();
        test_flush_deferred();
        test_backpressure();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
